mgt01_alu: RTL and testbench



---
 rtl/mgt01_alu.sv | 138 +++++++++++++
 tb/tb_mgt01_alu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mgt01_alu.sv
// Integer ALU of the MicroGT-01 execute stage: RV32I arithmetic, logic, shift and compare with registered outputs.
// Define MGT01_ALU_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit-per-cycle iterative shifter.
module mgt01_alu #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] op_A_i,
  input  logic [DATA_W-1:0] op_B_i,
  input  logic [3:0]        ops_i,
  output logic [DATA_W-1:0] result_o,
  output logic              comparison_o,
  output logic              valid_o,
  output logic              fu_state_o
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL = 4'd2,  OP_SRL = 4'd3,
    OP_SRA  = 4'd4,  OP_AND  = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_EQ  = 4'd10, OP_NE  = 4'd11,
    OP_LT   = 4'd12, OP_GE   = 4'd13, OP_LTU = 4'd14, OP_GEU = 4'd15
  } alu_ops_e;

  alu_ops_e          op;
  logic [4:0]        shamt;
  logic              lt_s;
  logic              lt_u;
  logic              eq;
  logic [DATA_W-1:0] comb_res;
  logic              comb_cmp;

  assign op    = alu_ops_e'(ops_i);
  assign shamt = op_B_i[4:0];
  assign lt_s  = $signed(op_A_i) < $signed(op_B_i);
  assign lt_u  = op_A_i < op_B_i;
  assign eq    = op_A_i == op_B_i;

  always_comb begin
    comb_res = '0;
    comb_cmp = 1'b0;
    case (op)
      OP_ADD:  comb_res = op_A_i + op_B_i;
      OP_SUB:  comb_res = op_A_i - op_B_i;
      OP_SLL:  comb_res = op_A_i << shamt;
      OP_SRL:  comb_res = op_A_i >> shamt;
      OP_SRA:  comb_res = $unsigned($signed(op_A_i) >>> shamt);
      OP_AND:  comb_res = op_A_i & op_B_i;
      OP_OR:   comb_res = op_A_i | op_B_i;
      OP_XOR:  comb_res = op_A_i ^ op_B_i;
      OP_SLT:  comb_cmp = lt_s;
      OP_SLTU: comb_cmp = lt_u;
      OP_EQ:   comb_cmp = eq;
      OP_NE:   comb_cmp = !eq;
      OP_LT:   comb_cmp = lt_s;
      OP_GE:   comb_cmp = !lt_s;
      OP_LTU:  comb_cmp = lt_u;
      OP_GEU:  comb_cmp = !lt_u;
      default: comb_cmp = 1'b0;
    endcase
    // Set/compare ops report the predicate in bit 0 of the result as well.
    if (ops_i[3]) comb_res = {{(DATA_W-1){1'b0}}, comb_cmp};
  end

`ifdef MGT01_ALU_SERIAL_SHIFT_EN
  logic              busy_reg;
  logic [4:0]        cnt_reg;
  logic [DATA_W-1:0] sh_reg;
  alu_ops_e          sh_op_reg;
  logic [DATA_W-1:0] sh_step;
  logic              is_shift;

  assign is_shift   = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign fu_state_o = busy_reg;

  always_comb begin
    case (sh_op_reg)
      OP_SLL:  sh_step = {sh_reg[DATA_W-2:0], 1'b0};
      OP_SRA:  sh_step = {sh_reg[DATA_W-1], sh_reg[DATA_W-1:1]};
      default: sh_step = {1'b0, sh_reg[DATA_W-1:1]};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o     <= '0;
      comparison_o <= 1'b0;
      valid_o      <= 1'b0;
      busy_reg     <= 1'b0;
      cnt_reg      <= '0;
      sh_reg       <= '0;
      sh_op_reg    <= OP_SLL;
    end else begin
      valid_o <= 1'b0;
      if (busy_reg) begin
        // Last step writes straight to the output so the pulse lands k edges after issue.
        if (cnt_reg == 5'd1) begin
          result_o     <= sh_step;
          comparison_o <= 1'b0;
          valid_o      <= 1'b1;
          busy_reg     <= 1'b0;
        end else begin
          sh_reg <= sh_step;
        end
        cnt_reg <= cnt_reg - 5'd1;
      end else if (valid_i) begin
        if (is_shift && shamt != 5'd0) begin
          busy_reg  <= 1'b1;
          cnt_reg   <= shamt;
          sh_reg    <= op_A_i;
          sh_op_reg <= op;
        end else begin
          result_o     <= comb_res;
          comparison_o <= comb_cmp;
          valid_o      <= 1'b1;
        end
      end
    end
  end
`else
  assign fu_state_o = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o     <= '0;
      comparison_o <= 1'b0;
      valid_o      <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        result_o     <= comb_res;
        comparison_o <= comb_cmp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mgt01_alu.sv
// Directed bench for mgt01_alu: expected results are queued at issue and checked when valid_o is due.
module tb_mgt01_alu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] op_A_i;
  logic [31:0] op_B_i;
  logic [3:0]  ops_i;
  logic [31:0] result_o;
  logic        comparison_o;
  logic        valid_o;
  logic        fu_state_o;

  mgt01_alu #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .op_A_i(op_A_i), .op_B_i(op_B_i),
    .ops_i(ops_i), .result_o(result_o), .comparison_o(comparison_o),
    .valid_o(valid_o), .fu_state_o(fu_state_o)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 0, SUB = 1, SLL = 2, SRL = 3, SRA = 4, AND = 5, OR = 6, XOR = 7;
  localparam logic [3:0] SLT = 8, SLTU = 9, EQ = 10, NE = 11, LT = 12, GE = 13, LTU = 14, GEU = 15;

  typedef struct {
    logic [31:0] res;
    logic        cmp;
    int          iss;
    int          due;
    bit          long_op;
  } entry_t;

  entry_t      q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_res = 32'd0;
  logic        last_cmp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every cycle valid_o must match the scoreboard; between pulses outputs must hold.
  always begin
    bit exp_busy;
    @(posedge clk);
    #1;
    exp_busy = (q.size() > 0) && q[0].long_op && (cyc >= q[0].iss) && (cyc < q[0].due);
    chk("fu_state", {31'd0, fu_state_o}, {31'd0, exp_busy});
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("valid_pulse", {31'd0, valid_o}, 32'd1);
      chk("result", result_o, q[0].res);
      chk("comparison", {31'd0, comparison_o}, {31'd0, q[0].cmp});
      $display("txn cyc=%0d result=%h comparison=%b", cyc, result_o, comparison_o);
      last_res = q[0].res;
      last_cmp = q[0].cmp;
      void'(q.pop_front());
    end else begin
      chk("valid_idle", {31'd0, valid_o}, 32'd0);
      chk("hold_result", result_o, last_res);
      chk("hold_comparison", {31'd0, comparison_o}, {31'd0, last_cmp});
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_cmp);
    entry_t e;
    int n = 0;
    bit is_sh;
    @(negedge clk);
    while (fu_state_o === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", {31'd0, fu_state_o}, 32'd0);
    valid_i = 1'b1;
    ops_i   = op;
    op_A_i  = a;
    op_B_i  = b;
    is_sh   = (op == SLL) || (op == SRL) || (op == SRA);
    e.res = exp_res;
    e.cmp = exp_cmp;
    e.iss = cyc + 1;
`ifdef MGT01_ALU_SERIAL_SHIFT_EN
    e.long_op = is_sh && (b[4:0] != 5'd0);
`else
    e.long_op = 1'b0;
`endif
    e.due = cyc + 1 + (e.long_op ? int'(b[4:0]) : 0);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  initial begin
    int n;
    rst_i = 1'b1; valid_i = 1'b0; ops_i = 4'd0; op_A_i = 32'd0; op_B_i = 32'd0;
    #1;
    chk("reset_result", result_o, 32'd0);
    chk("reset_comparison", {31'd0, comparison_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_fu_state", {31'd0, fu_state_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    issue(ADD, 32'd100, 32'd200, 32'h0000012C, 1'b0);  idle(1);
    issue(ADD, 32'd100, 32'hFFFFFF38, 32'hFFFFFF9C, 1'b0);  idle(1);
    issue(ADD, 32'hFFFFFF9C, 32'hFFFFFF38, 32'hFFFFFED4, 1'b0);  idle(1);
    issue(SUB, 32'd500, 32'd200, 32'd300, 1'b0);  idle(1);
    issue(SUB, 32'd500, 32'hFFFFFF38, 32'd700, 1'b0);  idle(1);
    issue(SUB, 32'hFFFFFE0C, 32'hFFFFFF38, 32'hFFFFFED4, 1'b0);  idle(1);
    issue(SRL, 32'd3, 32'd5, 32'd0, 1'b0);  idle(1);
    issue(SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);  idle(1);
    issue(SLL, 32'd1, 32'd31, 32'h80000000, 1'b0);  idle(1);
    issue(SLL, 32'd1, 32'h25, 32'h00000020, 1'b0);  idle(1);
    issue(SRL, 32'hF0000000, 32'h24, 32'h0F000000, 1'b0);  idle(1);
    issue(SRA, 32'h7FFFFFFF, 32'd1, 32'h3FFFFFFF, 1'b0);  idle(1);
    issue(SLL, 32'h00001234, 32'd0, 32'h00001234, 1'b0);  idle(1);
    issue(AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    issue(OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
    issue(XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);  idle(1);
    issue(EQ,  32'd500, 32'd200, 32'd0, 1'b0);
    issue(EQ,  32'd200, 32'd200, 32'd1, 1'b1);
    issue(GE,  32'd500, 32'd200, 32'd1, 1'b1);
    issue(GE,  32'hFFFFFE0C, 32'd200, 32'd0, 1'b0);
    issue(GEU, 32'hFFFFFE0C, 32'd200, 32'd1, 1'b1);
    issue(SLT, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1);
    issue(SLTU, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0);
    issue(NE,  32'd1, 32'd2, 32'd1, 1'b1);
    issue(LT,  32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b1);
    issue(LTU, 32'h80000000, 32'h7FFFFFFF, 32'd0, 1'b0);
    issue(GE,  32'd5, 32'd5, 32'd1, 1'b1);
    issue(GEU, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    // Leaves comparison_o high so the following ADD must clear it.
    issue(LTU, 32'd0, 32'd1, 32'd1, 1'b1);
    issue(ADD, 32'd1, 32'd2, 32'd3, 1'b0);
    issue(SUB, 32'd10, 32'd3, 32'd7, 1'b0);
    issue(EQ,  32'd9, 32'd9, 32'd1, 1'b1);
    idle(4);

    // Reset while an op is in flight: outputs clear immediately and the op never completes.
    issue(SLL, 32'd1, 32'd10, 32'h00000400, 1'b0);
`ifdef MGT01_ALU_SERIAL_SHIFT_EN
    idle(3);
    chk("busy_mid_shift", {31'd0, fu_state_o}, 32'd1);
`endif
    #2;
    rst_i = 1'b1;
    q.delete();
    last_res = 32'd0;
    last_cmp = 1'b0;
    #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_comparison", {31'd0, comparison_o}, 32'd0);
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_fu_state", {31'd0, fu_state_o}, 32'd0);
    idle(2);
    rst_i = 1'b0;
    idle(2);
    issue(XOR, 32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 1'b0);
    idle(3);

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
